// File: rtl/boot_seq_pkg.sv
// Shared types for the boot download sequencer: FSM state encoding,
// core download address width and the ROM byte type.
package boot_seq_pkg;

  localparam int BOOT_DN_AW = 16;

  typedef logic [7:0]            boot_byte_t;
  typedef logic [BOOT_DN_AW-1:0] boot_addr_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ROMW  = 3'd2,
    S_WRITE = 3'd3,
    S_EXEC  = 3'd4,
    S_ERR   = 3'd5
  } boot_state_t;

endpackage

// File: rtl/boot_download_sequencer.sv
// Boot download sequencer: after start, copies ROM bytes 0..ROM_LEN-1 into
// core RAM through the dn_* download port, then pulses execute_enable.
// Optional feature macro: BOOT_CSUM_EN adds an 8-bit wrap checksum of the
// accepted bytes; a mismatch against EXP_CSUM ends in ERR instead of EXEC.
//
// Download handshake: dn_wr is the valid, !dn_wait is the ready. A byte is
// transferred on a clock edge where dn_wr=1 and dn_wait=0; while dn_wait=1
// the sequencer keeps dn_wr, dn_addr and dn_data stable. dn_wait is ignored
// whenever dn_wr=0.
module boot_download_sequencer
  import boot_seq_pkg::*;
#(
  parameter int         ROM_LEN   = 276,
  parameter int         ROM_AW    = 9,
  parameter boot_addr_t LOAD_BASE = 16'h0000,
  parameter boot_addr_t EXEC_ADDR = 16'h0000,
  parameter boot_byte_t EXP_CSUM  = 8'h00
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              dn_go,
  output logic              dn_wr,
  output logic [15:0]       dn_addr,
  output logic [7:0]        dn_data,
  input  logic              dn_wait,
  output logic              execute_enable,
  output logic [15:0]       execute_addr,
  output boot_state_t       dbg_state
);

  localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(ROM_LEN - 1);

  boot_state_t       state_q;
  logic [ROM_AW-1:0] idx_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              dn_go_q;
  logic              dn_wr_q;
  boot_addr_t        dn_addr_q;
  boot_byte_t        dn_data_q;
  logic              exec_en_q;
  logic [ROM_AW-1:0] idx_d;
  logic              csum_ok;

`ifdef BOOT_CSUM_EN
  boot_byte_t        csum_q;
  boot_byte_t        csum_d;
  logic              error_q;

  // Running sum including the byte being accepted this cycle decides EXEC vs ERR.
  always_comb begin
    csum_d  = csum_q + dn_data_q;
    csum_ok = (csum_d == EXP_CSUM);
  end

  assign error = error_q;
`else
  logic unused_exp_csum;

  assign csum_ok         = 1'b1;
  assign error           = 1'b0;
  assign unused_exp_csum = ^EXP_CSUM;
`endif

  assign idx_d = idx_q + ROM_AW'(1);

  // Sequencer FSM: rom_addr is loaded on entry to FETCH so a synchronous ROM
  // returns the byte during ROMW, giving three cycles per byte without stalls.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dn_go_q    <= 1'b0;
      dn_wr_q    <= 1'b0;
      dn_addr_q  <= '0;
      dn_data_q  <= '0;
      exec_en_q  <= 1'b0;
`ifdef BOOT_CSUM_EN
      csum_q     <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FETCH;
            idx_q      <= '0;
            rom_addr_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            dn_go_q    <= 1'b1;
`ifdef BOOT_CSUM_EN
            csum_q     <= '0;
            error_q    <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          state_q <= S_ROMW;
        end
        S_ROMW: begin
          dn_data_q <= rom_data;
          dn_addr_q <= LOAD_BASE + BOOT_DN_AW'(idx_q);
          dn_wr_q   <= 1'b1;
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          if (!dn_wait) begin
            dn_wr_q <= 1'b0;
`ifdef BOOT_CSUM_EN
            csum_q  <= csum_d;
`endif
            if (idx_q == LAST_IDX) begin
              dn_go_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              if (csum_ok) begin
                exec_en_q <= 1'b1;
                state_q   <= S_EXEC;
              end else begin
`ifdef BOOT_CSUM_EN
                error_q   <= 1'b1;
`endif
                state_q   <= S_ERR;
              end
            end else begin
              idx_q      <= idx_d;
              rom_addr_q <= idx_d;
              state_q    <= S_FETCH;
            end
          end
        end
        S_EXEC: begin
          exec_en_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        S_ERR: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign rom_addr       = rom_addr_q;
  assign dn_go          = dn_go_q;
  assign dn_wr          = dn_wr_q;
  assign dn_addr        = dn_addr_q;
  assign dn_data        = dn_data_q;
  assign execute_enable = exec_en_q;
  assign execute_addr   = EXEC_ADDR;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_boot_download_sequencer.sv
// Bench for boot_download_sequencer: a 276-byte ramp ROM instance and a
// 4-byte instance loading at 16'hFFFE to exercise address wrap.
module tb_boot_download_sequencer;
  import boot_seq_pkg::*;

  localparam int         LEN_A  = 276;
  localparam int         LEN_B  = 4;
  localparam boot_addr_t BASE_B = 16'hFFFE;
  localparam boot_addr_t EXEC_A = 16'h0000;
  localparam boot_addr_t EXEC_B = 16'h1234;

  function automatic logic [7:0] ramp_sum(input int n);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < n; k++) s = s + 8'(k);
    return s;
  endfunction

  localparam logic [7:0] CSUM_A_GOOD = ramp_sum(LEN_A);
  localparam logic [7:0] CSUM_B_BAD  = ramp_sum(LEN_B) + 8'h01;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  int   cyc;
  int   t0;

  initial clk = 1'b0;
  always #8 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A ----------------
  logic        start, dn_wait;
  logic        busy, done, error, dn_go, dn_wr, execute_enable;
  logic [8:0]  rom_addr;
  logic [7:0]  rom_data, dn_data;
  logic [15:0] dn_addr, execute_addr;
  boot_state_t dbg_state;

  always @(posedge clk) rom_data <= rom_addr[7:0];

  boot_download_sequencer #(
    .ROM_LEN(LEN_A), .ROM_AW(9), .LOAD_BASE(16'h0000), .EXEC_ADDR(EXEC_A),
`ifdef BOOT_CSUM_EN
    .EXP_CSUM(CSUM_A_GOOD)
`else
    .EXP_CSUM(8'h00)
`endif
  ) u_dut (
    .clk_sys(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .error(error), .rom_addr(rom_addr), .rom_data(rom_data), .dn_go(dn_go),
    .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wait(dn_wait),
    .execute_enable(execute_enable), .execute_addr(execute_addr),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT B (address wrap) ----------------
  logic        start_b, dn_wait_b;
  logic        busy_b, done_b, error_b, dn_go_b, dn_wr_b, exec_en_b;
  logic [1:0]  rom_addr_b;
  logic [7:0]  rom_data_b, dn_data_b;
  logic [15:0] dn_addr_b, execute_addr_b;
  boot_state_t dbg_state_b;

  always @(posedge clk) rom_data_b <= {6'b0, rom_addr_b};

  boot_download_sequencer #(
    .ROM_LEN(LEN_B), .ROM_AW(2), .LOAD_BASE(BASE_B), .EXEC_ADDR(EXEC_B),
    .EXP_CSUM(CSUM_B_BAD)
  ) u_dut_b (
    .clk_sys(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
    .error(error_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b), .dn_go(dn_go_b),
    .dn_wr(dn_wr_b), .dn_addr(dn_addr_b), .dn_data(dn_data_b), .dn_wait(dn_wait_b),
    .execute_enable(exec_en_b), .execute_addr(execute_addr_b),
    .dbg_state(dbg_state_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [15:0] exp_b_q[$];
  int   write_cnt, exec_cnt, exec_cyc;
  int   wcnt_b, exec_cnt_b;
  logic chk_timing;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Monitor A: accepted writes are popped and compared; exec pulses recorded.
  always @(negedge clk) begin
    logic [23:0] e;
    if (reset_n && dn_wr && !dn_wait) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", dn_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("dn_addr", dn_addr, e[23:8]);
        check("dn_data", dn_data, e[7:0]);
      end
      if (chk_timing) check("wr_cycle", cyc - t0 + 1, 3 * write_cnt + 3);
      write_cnt++;
    end
    if (execute_enable) begin
      exec_cnt++;
      exec_cyc = cyc - t0 + 1;
      check("exec_busy_low", {busy, dn_go}, 2'b00);
    end
  end

  // Monitor B: accepted addresses compared against the expected wrap sequence.
  always @(negedge clk) begin
    if (reset_n && dn_wr_b && !dn_wait_b) begin
      if (exp_b_q.size() == 0) check("b_unexpected_write", dn_addr_b, 32'hFFFF_FFFF);
      else check("b_dn_addr", dn_addr_b, exp_b_q.pop_front());
      check("b_exec_addr", execute_addr_b, EXEC_B);
      wcnt_b++;
    end
    if (exec_en_b) exec_cnt_b++;
  end

  // ---------------- driver tasks ----------------
  task automatic load_expected_a();
    for (int k = 0; k < LEN_A; k++) exp_q.push_back({16'(k), 8'(k)});
    write_cnt = 0;
    exec_cnt  = 0;
    exec_cyc  = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(done && !busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < 4000), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rom(input int v);
    int n;
    n = 0;
    while (rom_addr != 9'(v) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("wait_rom_addr", (n < 4000), 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_rom"},   rom_addr, 9'h000);
    check({tag, "_dngo"},  dn_go, 1'b0);
    check({tag, "_dnwr"},  dn_wr, 1'b0);
    check({tag, "_dnadr"}, dn_addr, 16'h0000);
    check({tag, "_dndat"}, dn_data, 8'h00);
    check({tag, "_exen"},  execute_enable, 1'b0);
    check({tag, "_exadr"}, execute_addr, EXEC_A);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    dn_wait    = 1'b0;
    start_b    = 1'b0;
    dn_wait_b  = 1'b0;
    chk_timing = 1'b0;
    write_cnt  = 0;
    exec_cnt   = 0;
    exec_cyc   = -1;
    wcnt_b     = 0;
    exec_cnt_b = 0;
    t0         = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_state", dbg_state, S_IDLE);
    check("reset_b_exen", exec_en_b, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: full copy with no stall, exact per-byte and exec timing
    load_expected_a();
    chk_timing = 1'b1;
    pulse_start();
    wait_done("t1_timeout");
    chk_timing = 1'b0;
    check("t1_writes", write_cnt, LEN_A);
    check("t1_exec_cnt", exec_cnt, 1);
    check("t1_exec_cyc", exec_cyc, 3 * LEN_A + 1);
    check("t1_done", done, 1'b1);
    check("t1_error", error, 1'b0);
    check("t1_q_empty", exp_q.size(), 0);

    // 2: five-cycle stall while byte 10 is presented
    load_expected_a();
    pulse_start();
    check("t2_done_cleared", done, 1'b0);
    wait_rom(10);
    dn_wait = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("t2_hold_wr", dn_wr, 1'b1);
      check("t2_hold_addr", dn_addr, 16'h000A);
      check("t2_hold_data", dn_data, 8'h0A);
    end
    @(posedge clk);
    #1;
    dn_wait = 1'b0;
    wait_done("t2_timeout");
    check("t2_writes", write_cnt, LEN_A);
    check("t2_exec_cnt", exec_cnt, 1);
    check("t2_exec_cyc", exec_cyc, 3 * LEN_A + 1 + 5);
    check("t2_q_empty", exp_q.size(), 0);

    // 3: start re-pulsed mid-copy is ignored
    load_expected_a();
    pulse_start();
    wait_rom(50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_busy", busy, 1'b1);
    wait_done("t3_timeout");
    check("t3_writes", write_cnt, LEN_A);
    check("t3_exec_cnt", exec_cnt, 1);
    check("t3_exec_cyc", exec_cyc, 3 * LEN_A + 1);
    check("t3_q_empty", exp_q.size(), 0);

    // 4: asynchronous reset at byte 100, then a clean restart from address 0
    load_expected_a();
    pulse_start();
    wait_rom(100);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("t4_abort");
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    load_expected_a();
    pulse_start();
    wait_done("t4_timeout");
    check("t4_writes", write_cnt, LEN_A);
    check("t4_exec_cnt", exec_cnt, 1);
    check("t4_q_empty", exp_q.size(), 0);

    // 6: four bytes loaded at 16'hFFFE wrap through 16'h0000
    exp_b_q.push_back(16'hFFFE);
    exp_b_q.push_back(16'hFFFF);
    exp_b_q.push_back(16'h0000);
    exp_b_q.push_back(16'h0001);
    wcnt_b = 0;
    exec_cnt_b = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int n = 0; n < 40 && !(done_b && !busy_b); n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("t6_done", done_b, 1'b1);
    check("t6_writes", wcnt_b, LEN_B);
    check("t6_q_empty", exp_b_q.size(), 0);
    check("t6_exec_addr", execute_addr_b, EXEC_B);
`ifdef BOOT_CSUM_EN
    check("t5_err_flag", error_b, 1'b1);
    check("t5_err_no_exec", exec_cnt_b, 0);
`else
    check("t6_error_tied", error_b, 1'b0);
    check("t6_exec_cnt", exec_cnt_b, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
